tx_ffe_sweep: RTL and testbench

Sequencing controller for the TX FFE. On request it sweeps every `tx_setting` code and lets the FFE ROM output settle after each change. It then counts bit errors from the downstream checker over a fixed dwell window and finally parks the FFE on the code with the fewest errors. It sits between the link-tuning control logic and the `tx_setting` input of the FFE, and runs in the same clock domain as the FFE ROM.

---
 rtl/tx_package.sv | 25 ++
 rtl/sat_counter.sv | 33 +++
 rtl/tx_ffe_sweep.sv | 150 +++++++++++++++
 tb/tb_tx_ffe_sweep.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_package.sv
// ---------------------------------------------------------------------------
// tx_package
// Shared definitions for the TX FFE path.
//   TX_SETTING_WIDTH        width of the FFE tx_setting code
//   TX_SWEEP_SETTLE_CYCLES  default settle time after each code change
//   TX_SWEEP_DWELL_CYCLES   default error-counting window per code
//   TX_SWEEP_ERR_WIDTH      default width of the saturating error counter
//   tx_sweep_state_t        state encoding of the tx_ffe_sweep controller
// ---------------------------------------------------------------------------
package tx_package;

  localparam int TX_SETTING_WIDTH       = 4;
  localparam int TX_SWEEP_SETTLE_CYCLES = 8;
  localparam int TX_SWEEP_DWELL_CYCLES  = 1024;
  localparam int TX_SWEEP_ERR_WIDTH     = 16;

  typedef enum logic [2:0] {
    SWEEP_IDLE    = 3'd0,
    SWEEP_SETTLE  = 3'd1,
    SWEEP_MEASURE = 3'd2,
    SWEEP_COMPARE = 3'd3,
    SWEEP_DONE    = 3'd4
  } tx_sweep_state_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk    clock
//   i_rst    synchronous active-high reset (clears the count)
//   i_clr    synchronous clear, has priority over i_en
//   i_en     increment request
//   o_count  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; once all-ones the count holds.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tx_ffe_sweep.sv
// ---------------------------------------------------------------------------
// tx_ffe_sweep
// Sweeps every TX FFE code, lets the ROM settle, counts checker errors over a
// dwell window and finally parks the FFE on the code with the fewest errors.
//   clk           system clock (same domain as the FFE ROM)
//   rst           synchronous active-high reset, aborts any sweep
//   start         sweep request, only looked at in IDLE
//   err           one-cycle pulse per bit error from the checker
//   tx_setting    code driven to the FFE (registered)
//   meas_en       high during the measurement window of each code
//   busy          high whenever not IDLE
//   done          one-cycle pulse at the end of the sweep
//   best_setting  code with the lowest error count (lower code wins ties)
//   best_err      error count of best_setting
// ---------------------------------------------------------------------------
module tx_ffe_sweep
  import tx_package::*;
#(
  parameter int SETTING_WIDTH = TX_SETTING_WIDTH,
  parameter int SETTLE_CYCLES = TX_SWEEP_SETTLE_CYCLES,
  parameter int DWELL_CYCLES  = TX_SWEEP_DWELL_CYCLES,
  parameter int ERR_WIDTH     = TX_SWEEP_ERR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     err,
  output logic [SETTING_WIDTH-1:0] tx_setting,
  output logic                     meas_en,
  output logic                     busy,
  output logic                     done,
  output logic [SETTING_WIDTH-1:0] best_setting,
  output logic [ERR_WIDTH-1:0]     best_err
);

  // One down-counter serves both SETTLE and MEASURE, so it is sized for the
  // longer of the two phases.
  localparam int MAX_CYCLES = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LOAD  = TIMER_W'(DWELL_CYCLES - 1);

  tx_sweep_state_t          r_state;
  logic [TIMER_W-1:0]       r_timer;
  logic [SETTING_WIDTH-1:0] r_tx_setting;
  logic                     r_meas_en;
  logic                     r_busy;
  logic                     r_done;
  logic [SETTING_WIDTH-1:0] r_best_setting;
  logic [ERR_WIDTH-1:0]     r_best_err;

  logic                     w_cnt_clr;
  logic                     w_cnt_en;
  logic [ERR_WIDTH-1:0]     w_err_count;

  // The counter is cleared when a sweep starts and after every compare, and
  // only listens to err inside the measurement window.
  assign w_cnt_clr = (r_state == SWEEP_COMPARE) || ((r_state == SWEEP_IDLE) && start);
  assign w_cnt_en  = (r_state == SWEEP_MEASURE) && err;

  sat_counter #(
    .WIDTH (ERR_WIDTH)
  ) u_err_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_err_count)
  );

  // Sweep FSM. Every output is a register updated on the transition into the
  // state it belongs to, so nothing combinational reaches the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= SWEEP_IDLE;
      r_timer        <= '0;
      r_tx_setting   <= '0;
      r_meas_en      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_best_setting <= '0;
      r_best_err     <= '1;
    end else begin
      case (r_state)
        SWEEP_IDLE: begin
          if (start) begin
            r_state        <= SWEEP_SETTLE;
            r_timer        <= SETTLE_LOAD;
            r_tx_setting   <= '0;
            r_best_setting <= '0;
            r_best_err     <= '1;
            r_busy         <= 1'b1;
          end
        end
        SWEEP_SETTLE: begin
          if (r_timer == '0) begin
            r_state   <= SWEEP_MEASURE;
            r_timer   <= DWELL_LOAD;
            r_meas_en <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        SWEEP_MEASURE: begin
          if (r_timer == '0) begin
            r_state   <= SWEEP_COMPARE;
            r_meas_en <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        SWEEP_COMPARE: begin
          // Strict less-than keeps the earlier (lower) code on a tie.
          if (w_err_count < r_best_err) begin
            r_best_err     <= w_err_count;
            r_best_setting <= r_tx_setting;
          end
          if (r_tx_setting == '1) begin
            r_state <= SWEEP_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= SWEEP_SETTLE;
            r_timer      <= SETTLE_LOAD;
            r_tx_setting <= r_tx_setting + 1'b1;
          end
        end
        SWEEP_DONE: begin
          r_state      <= SWEEP_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_tx_setting <= r_best_setting;
        end
        default: begin
          r_state   <= SWEEP_IDLE;
          r_meas_en <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_setting   = r_tx_setting;
  assign meas_en      = r_meas_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign best_setting = r_best_setting;
  assign best_err     = r_best_err;

endmodule

// File: tb/tb_tx_ffe_sweep.sv
// ---------------------------------------------------------------------------
// tb_tx_ffe_sweep
// Directed bench for tx_ffe_sweep with SETTING_WIDTH=2, SETTLE_CYCLES=4,
// DWELL_CYCLES=8, ERR_WIDTH=4 (13 cycles per code, done in cycle 53 after a
// start at edge 0). A second instance with DWELL_CYCLES=20 exercises
// counter saturation (25 cycles per code, done in cycle 101).
// ---------------------------------------------------------------------------
module tb_tx_ffe_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       err;
  logic [1:0] tx_setting;
  logic       meas_en;
  logic       busy;
  logic       done;
  logic [1:0] best_setting;
  logic [3:0] best_err;

  logic       start2;
  logic       err2;
  logic [1:0] tx_setting2;
  logic       meas_en2;
  logic       busy2;
  logic       done2;
  logic [1:0] best_setting2;
  logic [3:0] best_err2;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tx_ffe_sweep #(
    .SETTING_WIDTH (2),
    .SETTLE_CYCLES (4),
    .DWELL_CYCLES  (8),
    .ERR_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .err          (err),
    .tx_setting   (tx_setting),
    .meas_en      (meas_en),
    .busy         (busy),
    .done         (done),
    .best_setting (best_setting),
    .best_err     (best_err)
  );

  tx_ffe_sweep #(
    .SETTING_WIDTH (2),
    .SETTLE_CYCLES (4),
    .DWELL_CYCLES  (20),
    .ERR_WIDTH     (4)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .err          (err2),
    .tx_setting   (tx_setting2),
    .meas_en      (meas_en2),
    .busy         (busy2),
    .done         (done2),
    .best_setting (best_setting2),
    .best_err     (best_err2)
  );

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " tx_setting"},   32'(tx_setting),   0);
    checkOutput({tag, " meas_en"},      32'(meas_en),      0);
    checkOutput({tag, " busy"},         32'(busy),         0);
    checkOutput({tag, " done"},         32'(done),         0);
    checkOutput({tag, " best_setting"}, 32'(best_setting), 0);
    checkOutput({tag, " best_err"},     32'(best_err),     15);
  endtask

  // Runs one sweep on the main instance. Cycle c (1..52) after the start edge
  // belongs to code (c-1)/13 at phase position p=(c-1)%13: p 0..3 settle,
  // 4..11 measure, 12 compare. mode 0 injects eN errors in the first measure
  // cycles of code N; mode 1 injects err only in settle and compare cycles.
  // stopAt returns early at that cycle without clocking it.
  task automatic applyStimulus(input string name, input int e0, input int e1, input int e2,
                               input int e3, input int mode, input int startPulse,
                               input int stopAt, input int expBest, input int expErr);
    int errs[4];
    int measHigh;
    int doneSeen;
    errs     = '{e0, e1, e2, e3};
    measHigh = 0;
    doneSeen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      int code;
      int p;
      code = (c - 1) / 13;
      p    = (c - 1) % 13;
      checkOutput({name, " tx_setting"}, 32'(tx_setting), code);
      checkOutput({name, " meas_en"}, 32'(meas_en), ((p >= 4) && (p <= 11)) ? 1 : 0);
      checkOutput({name, " busy"}, 32'(busy), 1);
      if (meas_en) measHigh++;
      if (done) doneSeen++;
      if (c == stopAt) return;
      if (mode == 0) err = (p >= 4) && ((p - 4) < errs[code]);
      else           err = (p < 4) || (p == 12);
      start = (c == startPulse);
      tick();
    end
    err   = 1'b0;
    start = 1'b0;
    checkOutput({name, " early_done"},    32'(doneSeen),   0);
    checkOutput({name, " meas_cycles"},   32'(measHigh),   32);
    checkOutput({name, " done@53"},       32'(done),       1);
    checkOutput({name, " busy@53"},       32'(busy),       1);
    checkOutput({name, " tx_setting@53"}, 32'(tx_setting), 3);
    tick();
    checkOutput({name, " done@54"},       32'(done),         0);
    checkOutput({name, " busy@54"},       32'(busy),         0);
    checkOutput({name, " parked"},        32'(tx_setting),   expBest);
    checkOutput({name, " best_setting"},  32'(best_setting), expBest);
    checkOutput({name, " best_err"},      32'(best_err),     expErr);
  endtask

  initial begin
    int satCycle;
    rst    = 1'b1;
    start  = 1'b0;
    err    = 1'b0;
    start2 = 1'b0;
    err2   = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    checkOutput("reset sat best_err", 32'(best_err2), 15);
    checkOutput("reset sat busy",     32'(busy2),     0);
    rst = 1'b0;
    tick();

    // Basic sweep: 5,2,7,3 errors, code 1 wins with 2.
    applyStimulus("basic", 5, 2, 7, 3, 0, 0, 0, 1, 2);

    // Tie between codes 1 and 2: the lower code is kept.
    applyStimulus("tie", 3, 1, 1, 4, 0, 0, 0, 1, 1);

    // err only outside the measure window: nothing counted.
    applyStimulus("window", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // start pulsed mid-sweep is ignored; one done only.
    applyStimulus("midstart", 4, 6, 2, 5, 0, 20, 0, 2, 2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("midstart idle busy", 32'(busy), 0);
      checkOutput("midstart idle done", 32'(done), 0);
      tick();
    end

    // Reset in the code 2 measure window (cycle 33) aborts the sweep.
    applyStimulus("abort", 2, 1, 5, 5, 0, 0, 33, 0, 0);
    rst = 1'b1;
    err = 1'b0;
    tick();
    checkResetState("abort");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort idle done", 32'(done), 0);
      checkOutput("abort idle busy", 32'(busy), 0);
    end
    applyStimulus("rerun", 6, 3, 8, 4, 0, 0, 0, 1, 3);

    // Saturation: err held high, 20 errors per code clamp to 15.
    satCycle = -1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    err2   = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      if (done2) begin
        satCycle = c;
        break;
      end
      tick();
    end
    err2 = 1'b0;
    checkOutput("sat done cycle",   32'(satCycle),      101);
    checkOutput("sat best_setting", 32'(best_setting2), 0);
    checkOutput("sat best_err",     32'(best_err2),     15);
    tick();
    checkOutput("sat parked",       32'(tx_setting2),   0);
    checkOutput("sat busy",         32'(busy2),         0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
